// File: rtl/fns_decoder_6_2.sv
// fns_decoder_6_2
// Sequential Fibonacci-number-system decoder for the receive side of a
// 6-signal / 2-redundant TSV bundle. A received 8-TSV codeword and the
// repair logic's per-TSV enable mask are latched, then walked one TSV per
// clock. Every enabled TSV receives the next Fibonacci weight
// (1, 2, 3, 5, 8, ...) and its bit is accumulated into a binary value.
// Disabled TSVs are skipped without advancing the weight sequence, which
// keeps the weights aligned with the transmit-side adder chain.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   codeword and mask are valid
//   in_ready   decoder can accept a codeword (IDLE only)
//   tsv_data   received TSV bits, bit 0 is the first TSV
//   en_flag    per-TSV enable, 0 = faulty or unused, bit 0 is the first TSV
//   out_valid  decoded result is valid (DONE)
//   out_ready  downstream accepts the result
//   dec_value  decoded 7-bit binary value
//   err        fewer than 6 TSVs enabled, codeword is unrepairable
module fns_decoder_6_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] tsv_data,
   input  logic [7:0] en_flag,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] dec_value,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  data_q;
   logic [7:0]  en_q;
   logic [6:0]  acc;
   logic [6:0]  fib_a;
   logic [6:0]  fib_b;
   logic [6:0]  weight;
   logic [2:0]  pos;
   logic [3:0]  cnt;

   // The weight for the current enabled TSV is the sum of the two previous
   // weights. Starting from A=0, B=1 this yields 1, 2, 3, 5, ... and never
   // exceeds 34, so 7 bits are enough for both the weight and the total.
   assign weight = fib_a + fib_b;

   // State register. Reset from any state returns to IDLE, which discards a
   // codeword that is still being walked or waiting in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers. The codeword and mask are captured on accept and
   // only these latched copies are used afterwards, so the inputs are free
   // to change while the walk is in progress. A disabled position only
   // advances the position counter; the weight pair, accumulator and
   // enabled-count all hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= 8'd0;
         en_q   <= 8'd0;
         acc    <= 7'd0;
         fib_a  <= 7'd0;
         fib_b  <= 7'd0;
         pos    <= 3'd0;
         cnt    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q <= tsv_data;
                  en_q   <= en_flag;
                  acc    <= 7'd0;
                  fib_a  <= 7'd0;
                  fib_b  <= 7'd1;
                  pos    <= 3'd0;
                  cnt    <= 4'd0;
               end
            end
            RUN: begin
               if (en_q[pos]) begin
                  if (data_q[pos]) begin
                     acc <= acc + weight;
                  end
                  fib_a <= fib_b;
                  fib_b <= weight;
                  cnt   <= cnt + 4'd1;
               end
               pos <= pos + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and output decode. in_ready is forced low while reset is
   // asserted so that nothing looks acceptable during reset. Results are
   // only presented in DONE and read as zero elsewhere; they come straight
   // from registers that do not change in DONE, so they stay stable for the
   // whole time out_valid is high, however long out_ready is held low.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      dec_value  = 7'd0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (pos == 3'd7) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            dec_value = acc;
            err       = (cnt < 4'd6);
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fns_decoder_6_2.sv
// tb_fns_decoder_6_2
// Self-checking bench for fns_decoder_6_2. Inputs are driven and outputs
// sampled on the falling clock edge. Expected results come from a
// behavioural model that ranks the enabled TSVs and looks up the Fibonacci
// weight of each rank, independent of the RTL's adder-pair formulation.
module tb_fns_decoder_6_2;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tsv_data;
   logic [7:0] en_flag;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] dec_value;
   logic       err;

   int checks;
   int passed;

   fns_decoder_6_2 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tsv_data  (tsv_data),
      .en_flag   (en_flag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dec_value (dec_value),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the n-th enabled TSV carries the n-th Fibonacci
   // weight; the codeword is unrepairable when fewer than six are enabled.
   function automatic void model(input logic [7:0] d, input logic [7:0] e,
                                 output int val, output bit er);
      int fib_w[8];
      int rank;
      fib_w[0] = 1;
      fib_w[1] = 2;
      for (int n = 2; n < 8; n++) fib_w[n] = fib_w[n-1] + fib_w[n-2];
      rank = 0;
      val  = 0;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) begin
            if (d[i]) val += fib_w[rank];
            rank++;
         end
      end
      er = (rank < 6);
   endfunction

   // Drives one codeword from IDLE, scrambles the inputs while it is being
   // walked, waits (bounded) for out_valid and returns the result along with
   // the number of edges from accept to out_valid. Releases DONE afterwards.
   task automatic run_codeword(input logic [7:0] d, input logic [7:0] e,
                               output int val, output bit er, output int lat);
      in_valid = 1'b1;
      tsv_data = d;
      en_flag  = e;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tsv_data = 8'($urandom);
         en_flag  = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      val = int'(dec_value);
      er  = err;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
      else passed++;
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      else passed++;
      checks++;
      if (dec_value !== 7'd0) $display("[TB] FAIL reset_dec_value: got %0d expected 0", dec_value);
      else passed++;
      checks++;
      if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err);
      else passed++;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_idle_ready: got %b expected 1", in_ready);
      else passed++;
   endtask

   task automatic test_vectors();
      logic [7:0] vd[5];
      logic [7:0] ve[5];
      int         vv[5];
      bit         vr[5];
      int         val, mval, lat;
      bit         er, mer;
      vd = '{8'h3F, 8'h08, 8'h40, 8'hFF, 8'h1F};
      ve = '{8'h3F, 8'h7B, 8'h7B, 8'hFF, 8'h1F};
      vv = '{32, 3, 13, 87, 19};
      vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         model(vd[i], ve[i], mval, mer);
         run_codeword(vd[i], ve[i], val, er, lat);
         checks++;
         if (val != vv[i] || val != mval)
            $display("[TB] FAIL vec%0d_value: got %0d expected %0d", i, val, vv[i]);
         else passed++;
         checks++;
         if (er !== vr[i] || er !== mer)
            $display("[TB] FAIL vec%0d_err: got %b expected %b", i, er, vr[i]);
         else passed++;
         checks++;
         if (lat != 8) $display("[TB] FAIL vec%0d_latency: got %0d expected 8", i, lat);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [7:0] d, e;
      int         val, mval, lat;
      bit         er, mer;
      for (int i = 0; i < 25; i++) begin
         d = 8'($urandom);
         e = (i % 3 == 0) ? 8'($urandom) : ~(8'd1 << $urandom_range(0, 7));
         model(d, e, mval, mer);
         run_codeword(d, e, val, er, lat);
         checks++;
         if (val != mval || er !== mer || lat != 8)
            $display("[TB] FAIL rand%0d d=%h e=%h: got value %0d err %b lat %0d expected value %0d err %b lat 8",
                     i, d, e, val, er, lat, mval, mer);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int val, mval, lat;
      bit er, mer;
      in_valid = 1'b1;
      tsv_data = 8'h3F;
      en_flag  = 8'h3F;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 8) $display("[TB] FAIL bp_latency: got %0d expected 8", lat);
      else passed++;
      // A competing codeword is offered while the result is stalled.
      in_valid = 1'b1;
      tsv_data = 8'h01;
      en_flag  = 8'h3F;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid c%0d: got %b expected 1", c, out_valid);
         else passed++;
         checks++;
         if (dec_value !== 7'd32) $display("[TB] FAIL bp_hold_value c%0d: got %0d expected 32", c, dec_value);
         else passed++;
         checks++;
         if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready);
         else passed++;
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_release_ready: got %b expected 0", in_ready);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("[TB] FAIL bp_idle: got valid %b ready %b expected valid 0 ready 1", out_valid, in_ready);
      else passed++;
      // in_valid is still held, so this idle cycle accepts the new codeword.
      model(8'h01, 8'h3F, mval, mer);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      val = int'(dec_value);
      er  = err;
      checks++;
      if (val != mval || er !== mer || lat != 8)
         $display("[TB] FAIL bp_second: got value %0d err %b lat %0d expected value %0d err %b lat 8",
                  val, er, lat, mval, mer);
      else passed++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int val, lat;
      bit er;
      bit seen;
      in_valid = 1'b1;
      tsv_data = 8'h3F;
      en_flag  = 8'h3F;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || dec_value !== 7'd0 || err !== 1'b0)
         $display("[TB] FAIL midrst_outputs: got valid %b ready %b value %0d err %b expected 0 0 0 0",
                  out_valid, in_ready, dec_value, err);
      else passed++;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL midrst_ready: got %b expected 1", in_ready);
      else passed++;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) $display("[TB] FAIL midrst_no_valid: got %b expected 0", seen);
      else passed++;
      run_codeword(8'h01, 8'h3F, val, er, lat);
      checks++;
      if (val != 1 || er !== 1'b0 || lat != 8)
         $display("[TB] FAIL midrst_next: got value %0d err %b lat %0d expected value 1 err 0 lat 8",
                  val, er, lat);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int res[2];
      int acc_cyc[2];
      int nres, nacc, cyc;
      bit acc_now;
      nres = 0;
      nacc = 0;
      cyc  = 0;
      res     = '{-1, -1};
      acc_cyc = '{0, 0};
      in_valid  = 1'b1;
      tsv_data  = 8'h3F;
      en_flag   = 8'h3F;
      out_ready = 1'b1;
      while (nres < 2 && cyc < 60) begin
         if (out_valid) begin
            res[nres] = int'(dec_value);
            nres++;
         end
         acc_now = in_ready && in_valid;
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (acc_now && nacc < 2) begin
            acc_cyc[nacc] = cyc;
            nacc++;
            if (nacc == 1) tsv_data = 8'h01;
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (nres != 2) $display("[TB] FAIL b2b_count: got %0d results expected 2", nres);
      else passed++;
      checks++;
      if (res[0] != 32) $display("[TB] FAIL b2b_first: got %0d expected 32", res[0]);
      else passed++;
      checks++;
      if (res[1] != 1) $display("[TB] FAIL b2b_second: got %0d expected 1", res[1]);
      else passed++;
      checks++;
      if (nacc != 2 || acc_cyc[1] - acc_cyc[0] != 10)
         $display("[TB] FAIL b2b_spacing: got %0d accepts %0d cycles apart expected 2 accepts 10 apart",
                  nacc, acc_cyc[1] - acc_cyc[0]);
      else passed++;
   endtask

   initial begin
      checks    = 0;
      passed    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tsv_data  = 8'h00;
      en_flag   = 8'h00;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
